pad_test_ctl_regs: RTL

- Register and sequencing block directly upstream of the chip-level pad/test mux stage. It produces the port_ctl[6:0] and test_ctl[5:0] control words that drive that stage's mux selects and pad controls.
- Written over a simple valid/ready write port.
- test_ctl writes are protected by a two-word unlock key with a timeout.
- A change of the test-mode select bit is followed by a settle window, during which further writes are stalled.

---
 rtl/pad_test_ctl_if.sv | 11 +
 rtl/pad_test_ctl_regs.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pad_test_ctl_if.sv
// Write port bundle for pad_test_ctl_regs: valid/ready handshake with address and data.
// The master drives the request, the slave (the register block) returns ready.
interface pad_test_ctl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pad_test_ctl_regs.sv
// Port/test control registers feeding the pad/test mux stage. test_ctl writes need a
// two-word key with timeout; toggling the test-mode bit stalls the write port to settle.
module pad_test_ctl_regs #(
  parameter logic [6:0]  PORT_RST   = 7'h20,
  parameter logic [5:0]  TEST_RST   = 6'h00,
  parameter logic [7:0]  KEY0       = 8'hA5,
  parameter logic [7:0]  KEY1       = 8'h5A,
  parameter int unsigned UNLOCK_TO  = 16,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pad_test_ctl_if.slave        wr,
  output logic [6:0]           port_ctl,
  output logic [5:0]           test_ctl,
  output logic                 locked,
  output logic                 wr_err
);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_KEY_A    = 2'd1,
    ST_UNLOCKED = 2'd2
  } state_t;

  localparam logic [7:0] TO_LOAD     = 8'(UNLOCK_TO);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

  state_t     state_r, state_s;
  logic [7:0] timer_r, timer_s;
  logic [3:0] settle_r, settle_s;
  logic [6:0] port_r, port_s;
  logic [5:0] test_r, test_s;
  logic       err_r, err_s;
  logic       locked_r;
  logic       ready_r;
  logic       accept_s;

  assign accept_s    = wr.wr_valid & ready_r;
  assign wr.wr_ready = ready_r;
  assign port_ctl    = port_r;
  assign test_ctl    = test_r;
  assign locked      = locked_r;
  assign wr_err      = err_r;

  // Next-state for key FSM, unlock timer, settle counter and control registers
  always_comb begin
    state_s  = state_r;
    timer_s  = timer_r;
    settle_s = settle_r;
    port_s   = port_r;
    test_s   = test_r;
    err_s    = 1'b0;

    if (settle_r != 4'd0) begin
      settle_s = settle_r - 4'd1;
    end else begin
      settle_s = 4'd0;
    end

    // Timer expiry is the default outcome; an accepted test_ctl write below still wins
    case (state_r)
      ST_UNLOCKED: begin
        if (timer_r != 8'd0) begin
          timer_s = timer_r - 8'd1;
        end else begin
          timer_s = 8'd0;
        end
        if (timer_r <= 8'd1) begin
          state_s = ST_LOCKED;
        end else begin
          state_s = ST_UNLOCKED;
        end
      end
      ST_LOCKED, ST_KEY_A: begin
        timer_s = timer_r;
      end
      default: begin
        state_s = ST_LOCKED;
      end
    endcase

    if (accept_s) begin
      case (wr.wr_addr)
        2'd0: begin
          port_s = wr.wr_data[6:0];
        end
        2'd1: begin
          if (state_r == ST_UNLOCKED) begin
            test_s = wr.wr_data[5:0];
            if (wr.wr_data[5] != test_r[5]) begin
              settle_s = SETTLE_LOAD;
            end else begin
              settle_s = 4'd0;
            end
          end else begin
            err_s = 1'b1;
          end
          state_s = ST_LOCKED;
        end
        2'd2: begin
          err_s = 1'b1;
          if (state_r == ST_KEY_A) begin
            state_s = ST_LOCKED;
          end else begin
            err_s = 1'b1;
          end
        end
        default: begin
          case (state_r)
            ST_LOCKED: begin
              if (wr.wr_data == KEY0) begin
                state_s = ST_KEY_A;
              end else begin
                state_s = ST_LOCKED;
                err_s   = 1'b1;
              end
            end
            ST_KEY_A: begin
              if (wr.wr_data == KEY1) begin
                state_s = ST_UNLOCKED;
                timer_s = TO_LOAD;
              end else if (wr.wr_data == KEY0) begin
                state_s = ST_KEY_A;
              end else begin
                state_s = ST_LOCKED;
                err_s   = 1'b1;
              end
            end
            ST_UNLOCKED: begin
              state_s = ST_LOCKED;
            end
            default: begin
              state_s = ST_LOCKED;
            end
          endcase
        end
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // State and output registers; locked and wr_ready are registered from next-state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_LOCKED;
      timer_r  <= 8'd0;
      settle_r <= 4'd0;
      port_r   <= PORT_RST;
      test_r   <= TEST_RST;
      err_r    <= 1'b0;
      locked_r <= 1'b1;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      settle_r <= settle_s;
      port_r   <= port_s;
      test_r   <= test_s;
      err_r    <= err_s;
      locked_r <= (state_s != ST_UNLOCKED);
      ready_r  <= (settle_s == 4'd0);
    end
  end

endmodule
